// File: rtl/uart_frame_ctrl.sv
// uart_frame_ctrl
//   Full-duplex UART for the DVS-to-SpiNNaker link. Word width, oversampling,
//   parity and stop-bit count are set by parameters. TX takes words from the
//   event packer through a valid/ready handshake. RX delivers words from the host
//   serial line as a one-cycle pulse, with per-frame parity and framing flags.
//
// Ports
//   clk_i            master clock
//   rst_i            asynchronous, active-high reset
//   rx_i             serial input (asynchronous, idle high)
//   tx_o             serial output (idle high)
//   tx_valid_i       word on tx_data_i is offered
//   tx_ready_o       high while TX is idle
//   tx_data_i        word to send, LSB first
//   rx_valid_o       one-cycle pulse: frame complete
//   rx_data_o        last received word, held until the next frame
//   rx_parity_err_o  qualifies rx_valid_o: parity mismatch
//   rx_frame_err_o   qualifies rx_valid_o: first stop bit sampled low
//   rx_busy_o        RX state is not IDLE
//   tx_state_o       debug: current TX FSM state
//   rx_state_o       debug: current RX FSM state
//
// Handshake: a word is accepted on any rising clk edge where tx_valid_i and
// tx_ready_o are both high. tx_ready_o depends only on TX state and never on
// tx_valid_i. While tx_ready_o is low, tx_valid_i and tx_data_i are ignored.
// rx_valid_o has no back-pressure, so the consumer must take rx_data_o and the
// error flags in the cycle the pulse is high.

module uart_frame_ctrl #(
    parameter int CLK_DIV    = 1085,
    parameter int OVERSAMPLE = 4,
    parameter int DATA_BITS  = 32,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0,
    parameter int STOP_BITS  = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 tx_o,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    input  logic [DATA_BITS-1:0] tx_data_i,
    output logic                 rx_valid_o,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_parity_err_o,
    output logic                 rx_frame_err_o,
    output logic                 rx_busy_o,
    output logic [2:0]           tx_state_o,
    output logic [2:0]           rx_state_o
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int TCK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [DIV_W-1:0] DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [TCK_W-1:0] TCK_LAST  = TCK_W'(OVERSAMPLE - 1);
    localparam logic [TCK_W-1:0] TCK_HALF  = TCK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_e;

    // ---------------------------------------------------------------- TX
    tx_state_e              tx_state_q, tx_state_d;
    logic [DIV_W-1:0]       tx_div_q, tx_div_d;
    logic [TCK_W-1:0]       tx_tck_q, tx_tck_d;
    logic [BIT_W-1:0]       tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d;
    logic                   tx_tick, tx_bit_end;

    // The divider is held at its reload value while idle. This makes the first
    // bit period after an accept a full one, so bit timing lines up with the frame.
    assign tx_tick    = (tx_state_q != TX_IDLE) && (tx_div_q == '0);
    assign tx_bit_end = tx_tick && (tx_tck_q == TCK_LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_div_q   <= DIV_MAX;
            tx_tck_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_tck_q   <= tx_tck_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_div_d   = DIV_MAX;
        tx_tck_d   = '0;
        if (tx_state_q != TX_IDLE) begin
            tx_div_d = tx_tick ? DIV_MAX : tx_div_q - DIV_W'(1);
            tx_tck_d = tx_bit_end ? '0 : (tx_tick ? tx_tck_q + TCK_W'(1) : tx_tck_q);
        end
        case (tx_state_q)
            TX_IDLE: begin
                if (tx_valid_i) begin
                    tx_state_d = TX_START;
                    tx_shift_d = tx_data_i;
                    tx_par_d   = (^tx_data_i) ^ PARITY_ODD;
                    tx_bit_d   = '0;
                end
            end
            TX_START: begin
                if (tx_bit_end) tx_state_d = TX_DATA;
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = PARITY_EN ? TX_PARITY : TX_STOP;
                        tx_bit_d   = '0;
                    end else begin
                        tx_bit_d = tx_bit_q + BIT_W'(1);
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) tx_state_d = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_q == STOP_LAST) tx_state_d = TX_IDLE;
                    else tx_bit_d = tx_bit_q + BIT_W'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_o       = 1'b1;
        tx_ready_o = 1'b0;
        case (tx_state_q)
            TX_IDLE:   tx_ready_o = 1'b1;
            TX_START:  tx_o = 1'b0;
            TX_DATA:   tx_o = tx_shift_q[0];
            TX_PARITY: tx_o = tx_par_q;
            default:   tx_o = 1'b1;
        endcase
    end

    assign tx_state_o = tx_state_q;

    // ---------------------------------------------------------------- RX
    rx_state_e              rx_state_q, rx_state_d;
    logic                   rx_meta_q, rx_s_q;
    logic [DIV_W-1:0]       rx_div_q, rx_div_d;
    logic [TCK_W-1:0]       rx_tck_q, rx_tck_d;
    logic [BIT_W-1:0]       rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic                   rx_perr_q, rx_perr_d;
    logic                   rx_valid_q, rx_valid_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_perr_out_q, rx_perr_out_d;
    logic                   rx_ferr_q, rx_ferr_d;
    logic                   rx_active, rx_tick, rx_sample;

    // The divider runs only inside a frame. The first sample comes half a bit
    // after the start edge, and each later sample a full bit after the one
    // before it, so every sample lands mid-bit.
    assign rx_active = (rx_state_q == RX_START) || (rx_state_q == RX_DATA) ||
                       (rx_state_q == RX_PARITY) || (rx_state_q == RX_STOP);
    assign rx_tick   = rx_active && (rx_div_q == '0);
    assign rx_sample = rx_tick &&
                       (rx_tck_q == ((rx_state_q == RX_START) ? TCK_HALF : TCK_LAST));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q     <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_div_q      <= DIV_MAX;
            rx_tck_q      <= '0;
            rx_bit_q      <= '0;
            rx_shift_q    <= '0;
            rx_perr_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_data_q     <= '0;
            rx_perr_out_q <= 1'b0;
            rx_ferr_q     <= 1'b0;
        end else begin
            rx_meta_q     <= rx_i;
            rx_s_q        <= rx_meta_q;
            rx_state_q    <= rx_state_d;
            rx_div_q      <= rx_div_d;
            rx_tck_q      <= rx_tck_d;
            rx_bit_q      <= rx_bit_d;
            rx_shift_q    <= rx_shift_d;
            rx_perr_q     <= rx_perr_d;
            rx_valid_q    <= rx_valid_d;
            rx_data_q     <= rx_data_d;
            rx_perr_out_q <= rx_perr_out_d;
            rx_ferr_q     <= rx_ferr_d;
        end
    end

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_bit_d      = rx_bit_q;
        rx_shift_d    = rx_shift_q;
        rx_perr_d     = rx_perr_q;
        rx_valid_d    = 1'b0;
        rx_data_d     = rx_data_q;
        rx_perr_out_d = rx_perr_out_q;
        rx_ferr_d     = rx_ferr_q;
        rx_div_d      = DIV_MAX;
        rx_tck_d      = '0;
        if (rx_active) begin
            rx_div_d = rx_tick ? DIV_MAX : rx_div_q - DIV_W'(1);
            rx_tck_d = rx_sample ? '0 : (rx_tick ? rx_tck_q + TCK_W'(1) : rx_tck_q);
        end
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s_q) rx_state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (rx_sample) begin
                    rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
                    rx_bit_d   = '0;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = DATA_BITS'({rx_s_q, rx_shift_q} >> 1);
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = PARITY_EN ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + BIT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_perr_d  = ((^rx_shift_q) ^ rx_s_q) != PARITY_ODD;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_valid_d    = 1'b1;
                    rx_data_d     = rx_shift_q;
                    rx_perr_out_d = PARITY_EN ? rx_perr_q : 1'b0;
                    rx_ferr_d     = !rx_s_q;
                    // A low stop bit may be the start of a break. Wait for the
                    // line to go idle so the low level is not taken as a new start.
                    rx_state_d    = rx_s_q ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_s_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_busy_o       = (rx_state_q != RX_IDLE);
        rx_valid_o      = rx_valid_q;
        rx_data_o       = rx_data_q;
        rx_parity_err_o = rx_perr_out_q;
        rx_frame_err_o  = rx_ferr_q;
    end

    assign rx_state_o = rx_state_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Bench for uart_frame_ctrl with CLK_DIV=4 and OVERSAMPLE=4, which gives 16 clk per bit.
// Instance u_a: 8 data bits, no parity, 1 stop bit.
// Instance u_b: 32 data bits, even parity, 2 stop bits. Its rx input comes
// either from its own tx (loopback) or from a bench-driven line.

module tb_uart_frame_ctrl;

    localparam int BIT_CLK = 16;

    typedef struct packed {
        logic [31:0] data;
        logic        perr;
        logic        ferr;
    } rx_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    rx_exp_t exp_a_q[$];
    rx_exp_t exp_b_q[$];
    logic    tx_exp_q[$];

    // instance a
    logic       rx_a_drv   = 1'b1;
    logic       tx_valid_a = 1'b0;
    logic [7:0] tx_data_a  = '0;
    logic       tx_a, tx_ready_a, rx_valid_a, perr_a, ferr_a, busy_a;
    logic [7:0] rx_data_a;
    logic [2:0] tx_state_a, rx_state_a;

    // instance b
    logic        rx_b_drv   = 1'b1;
    logic        loop_b     = 1'b0;
    logic        tx_valid_b = 1'b0;
    logic [31:0] tx_data_b  = '0;
    logic        rx_b, tx_b, tx_ready_b, rx_valid_b, perr_b, ferr_b, busy_b;
    logic [31:0] rx_data_b;
    logic [2:0]  tx_state_b, rx_state_b;

    assign rx_b = loop_b ? tx_b : rx_b_drv;

    uart_frame_ctrl #(
        .CLK_DIV(4), .OVERSAMPLE(4), .DATA_BITS(8),
        .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)
    ) u_a (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_a_drv), .tx_o(tx_a),
        .tx_valid_i(tx_valid_a), .tx_ready_o(tx_ready_a), .tx_data_i(tx_data_a),
        .rx_valid_o(rx_valid_a), .rx_data_o(rx_data_a),
        .rx_parity_err_o(perr_a), .rx_frame_err_o(ferr_a), .rx_busy_o(busy_a),
        .tx_state_o(tx_state_a), .rx_state_o(rx_state_a)
    );

    uart_frame_ctrl #(
        .CLK_DIV(4), .OVERSAMPLE(4), .DATA_BITS(32),
        .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)
    ) u_b (
        .clk_i(clk), .rst_i(rst), .rx_i(rx_b), .tx_o(tx_b),
        .tx_valid_i(tx_valid_b), .tx_ready_o(tx_ready_b), .tx_data_i(tx_data_b),
        .rx_valid_o(rx_valid_b), .rx_data_o(rx_data_b),
        .rx_parity_err_o(perr_b), .rx_frame_err_o(ferr_b), .rx_busy_o(busy_b),
        .tx_state_o(tx_state_b), .rx_state_o(rx_state_b)
    );

    // ------------------------------------------------------------ driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input bit sel_b, input logic [63:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_b) rx_b_drv = bits[i];
            else       rx_a_drv = bits[i];
            repeat (BIT_CLK) step();
        end
    endtask

    // Offer a word to u_b and hold it until it is accepted. Returns the number
    // of cycles spent waiting for tx_ready.
    task automatic send_b(input logic [31:0] d, input int budget, output int waited);
        bit done = 0;
        waited = 0;
        tx_valid_b = 1'b1;
        tx_data_b  = d;
        for (int i = 0; i < budget && !done; i++) begin
            if (tx_ready_b) done = 1;
            else waited++;
            step();
        end
        tx_valid_b = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL send_b_accept: word %h not accepted within %0d clk", d, budget);
        end
    endtask

    // ------------------------------------------------------------ scoreboard
    task automatic expect_rx(input bit sel_b, input int budget, input string name);
        bit      got = 0;
        rx_exp_t e;
        rx_exp_t act;
        for (int i = 0; i < budget && !got; i++) begin
            step();
            if (sel_b ? rx_valid_b : rx_valid_a) got = 1;
        end
        act.data = sel_b ? rx_data_b : {24'h0, rx_data_a};
        act.perr = sel_b ? perr_b : perr_a;
        act.ferr = sel_b ? ferr_b : ferr_a;
        if (sel_b) e = exp_b_q.pop_front();
        else       e = exp_a_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s: no rx_valid within %0d clk, expected data=%h", name, budget, e.data);
        end else if (act !== e) begin
            failures++;
            $display("FAIL %s: got data=%h perr=%b ferr=%b, expected data=%h perr=%b ferr=%b",
                     name, act.data, act.perr, act.ferr, e.data, e.perr, e.ferr);
        end
    endtask

    task automatic expect_no_rx(input bit sel_b, input int cycles, input string name);
        int pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (sel_b ? rx_valid_b : rx_valid_a) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL %s: got %0d rx_valid pulses, expected 0", name, pulses);
        end
    endtask

    // Send one word on u_a and check the tx line bit by bit against the frame
    // pushed into tx_exp_q. The caller must be at posedge+1 with u_a idle.
    task automatic send_check_a(input logic [7:0] d, input string name);
        logic exp_bit;
        int   bad;
        tx_exp_q.delete();
        tx_exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) tx_exp_q.push_back(d[i]);
        tx_exp_q.push_back(1'b1);
        checks++;
        if (tx_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_before: got %b, expected 1", name, tx_ready_a);
        end
        tx_valid_a = 1'b1;
        tx_data_a  = d;
        step();
        // While busy, offer a different word. It must be ignored.
        tx_data_a = ~d;
        checks++;
        if (tx_ready_a !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_after_accept: got %b, expected 0", name, tx_ready_a);
        end
        for (int b = 0; b < 10; b++) begin
            exp_bit = tx_exp_q.pop_front();
            bad = 0;
            if (b == 9) tx_valid_a = 1'b0;
            for (int c = 0; c < BIT_CLK; c++) begin
                if (tx_a !== exp_bit) bad++;
                if (b == 9 && c == BIT_CLK - 1) begin
                    checks++;
                    if (tx_ready_a !== 1'b0) begin
                        failures++;
                        $display("FAIL %s_ready_early: got %b at clk 159, expected 0", name, tx_ready_a);
                    end
                end
                step();
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL %s_bit%0d: %0d of 16 clk wrong, expected level %b", name, b, bad, exp_bit);
            end
        end
        checks++;
        if (tx_ready_a !== 1'b1) begin
            failures++;
            $display("FAIL %s_ready_160: got %b, expected 1", name, tx_ready_a);
        end
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++;
        if ({tx_a, tx_ready_a, rx_valid_a, perr_a, ferr_a, busy_a} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_a_flags: got tx,rdy,vld,perr,ferr,busy=%b, expected 110000",
                     {tx_a, tx_ready_a, rx_valid_a, perr_a, ferr_a, busy_a});
        end
        checks++;
        if (rx_data_a !== 8'h00) begin
            failures++;
            $display("FAIL reset_a_data: got %h, expected 00", rx_data_a);
        end
        checks++;
        if ({tx_b, tx_ready_b, rx_valid_b, perr_b, ferr_b, busy_b} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_b_flags: got tx,rdy,vld,perr,ferr,busy=%b, expected 110000",
                     {tx_b, tx_ready_b, rx_valid_b, perr_b, ferr_b, busy_b});
        end
        checks++;
        if (rx_data_b !== 32'h0) begin
            failures++;
            $display("FAIL reset_b_data: got %h, expected 00000000", rx_data_b);
        end
        checks++;
        if ({tx_state_a, rx_state_a, tx_state_b, rx_state_b} !== 12'h000) begin
            failures++;
            $display("FAIL reset_states: got %h, expected 000",
                     {tx_state_a, rx_state_a, tx_state_b, rx_state_b});
        end
        rst = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_tx_frame();
        send_check_a(8'hA5, "tx_a5");
        repeat (4) step();
        send_check_a(8'($urandom_range(0, 255)), "tx_rand");
        repeat (4) step();
    endtask

    task automatic test_back_to_back();
        int w0, w1;
        loop_b = 1'b1;
        exp_b_q.push_back('{32'hDEADBEEF, 1'b0, 1'b0});
        exp_b_q.push_back('{32'h00000001, 1'b0, 1'b0});
        fork
            begin
                send_b(32'hDEADBEEF, 10, w0);
                send_b(32'h00000001, 700, w1);
                // 1 start + 32 data + 1 parity + 2 stop bits
                checks++;
                if (w1 != 36 * BIT_CLK) begin
                    failures++;
                    $display("FAIL b2b_ready_gap: waited %0d clk, expected %0d", w1, 36 * BIT_CLK);
                end
            end
            begin
                expect_rx(1'b1, 700, "loop_deadbeef");
                expect_rx(1'b1, 700, "loop_00000001");
            end
        join
        expect_no_rx(1'b1, 100, "loop_extra_pulse");
        loop_b = 1'b0;
        repeat (4) step();
    endtask

    task automatic test_parity();
        logic [63:0] fr;
        logic [31:0] w;
        // 0x3C has four ones, so even parity is 0. Send it inverted.
        fr = '0;
        fr[32:1] = 32'h0000003C;
        fr[33]   = 1'b1;
        fr[34]   = 1'b1;
        exp_b_q.push_back('{32'h0000003C, 1'b1, 1'b0});
        fork
            drive_rx(1'b1, fr, 35);
            expect_rx(1'b1, 40 * BIT_CLK, "parity_err_3c");
        join
        repeat (4) step();
        w = $urandom;
        fr = '0;
        fr[32:1] = w;
        fr[33]   = ^w;
        fr[34]   = 1'b1;
        exp_b_q.push_back('{w, 1'b0, 1'b0});
        fork
            drive_rx(1'b1, fr, 35);
            expect_rx(1'b1, 40 * BIT_CLK, "parity_ok_rand");
        join
        repeat (4) step();
    endtask

    task automatic test_frame_err();
        logic [63:0] fr;
        fr = '0;
        fr[8:1] = 8'h81;
        fr[9]   = 1'b0;
        exp_a_q.push_back('{32'h00000081, 1'b0, 1'b1});
        fork
            begin
                drive_rx(1'b0, fr, 10);
                repeat (100) step();
                rx_a_drv = 1'b1;
            end
            begin
                expect_rx(1'b0, 200, "frame_err_81");
                expect_no_rx(1'b0, 60, "wait_high_quiet");
            end
        join
        repeat (5) step();
        checks++;
        if (busy_a !== 1'b0) begin
            failures++;
            $display("FAIL wait_high_release: rx_busy got %b, expected 0", busy_a);
        end
        fr = '0;
        fr[8:1] = 8'h55;
        fr[9]   = 1'b1;
        exp_a_q.push_back('{32'h00000055, 1'b0, 1'b0});
        fork
            drive_rx(1'b0, fr, 10);
            expect_rx(1'b0, 200, "after_break_55");
        join
        repeat (4) step();
    endtask

    task automatic test_glitch();
        bit saw_busy = 0;
        int drop_at  = -1;
        rx_a_drv = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 4) rx_a_drv = 1'b1;
            if (busy_a) saw_busy = 1;
            else if (saw_busy && drop_at < 0) drop_at = k;
        end
        checks++;
        if (!saw_busy || drop_at < 0) begin
            failures++;
            $display("FAIL glitch_busy: saw_busy=%0d drop_at=%0d, expected busy then drop by 12 clk",
                     saw_busy, drop_at);
        end
        expect_no_rx(1'b0, 40, "glitch_no_valid");
    endtask

    task automatic test_reset_mid_tx();
        // 0x52 has bit 3 = 0, so forcing the line high is visible.
        tx_valid_a = 1'b1;
        tx_data_a  = 8'h52;
        step();
        tx_valid_a = 1'b0;
        repeat (70) step();
        checks++;
        if (tx_a !== 1'b0) begin
            failures++;
            $display("FAIL mid_tx_bit3: got %b, expected 0", tx_a);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({tx_a, tx_ready_a} !== 2'b11) begin
            failures++;
            $display("FAIL rst_mid_tx: got tx,ready=%b, expected 11", {tx_a, tx_ready_a});
        end
        repeat (3) step();
        rst = 1'b0;
        step();
        send_check_a(8'hC3, "tx_after_rst");
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_parity();
        test_frame_err();
        test_glitch();
        test_reset_mid_tx();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
